// File: rtl/umi_multi_queue_arb_pkg.sv
// Shared types and helpers for the multi-queue UMI arbiter.
// Optional counter macro: UMI_MULTI_QUEUE_ARB_COUNT_EN (used by the top).
package umi_multi_queue_arb_pkg;

  localparam int unsigned UMI_EOM_BIT = 22;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Packed beat width: {data, srcaddr, dstaddr, cmd}.
  function automatic int unsigned umi_pkt_w(input int unsigned dw,
                                            input int unsigned aw,
                                            input int unsigned cw);
    return dw + 2 * aw + cw;
  endfunction

endpackage

// File: rtl/umi_chan_fifo.sv
// Per-channel beat FIFO: wrap-bit pointers, synchronous active-low reset,
// no pass-through when full.
module umi_chan_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam int unsigned PTRW = IW + 1;

  logic [PTRW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q[IW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PTRW'(1);
    if (do_pop)  rd_d = rd_q + PTRW'(1);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: it is only read while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[IW-1:0]] <= din_i;
  end

endmodule

// File: rtl/umi_multi_queue_arb.sv
// N-channel UMI merger: per-channel FIFOs, message-atomic round-robin arbiter,
// registered output. Optional beat counter: UMI_MULTI_QUEUE_ARB_COUNT_EN.
module umi_multi_queue_arb
  import umi_multi_queue_arb_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned DW      = 256,
  parameter int unsigned AW      = 64,
  parameter int unsigned CW      = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned EOM_BIT = UMI_EOM_BIT
) (
  input  logic                                 clk,
  input  logic                                 nreset,
  input  logic [N*umi_pkt_w(DW, AW, CW)-1:0]   in_data,
  input  logic [N-1:0]                         in_valid,
  output logic [N-1:0]                         in_ready,
  output logic [DW-1:0]                        data,
  output logic [AW-1:0]                        srcaddr,
  output logic [AW-1:0]                        dstaddr,
  output logic [CW-1:0]                        cmd,
  output logic [$clog2(N)-1:0]                 chan,
  output logic                                 valid,
  input  logic                                 ready,
  output logic [31:0]                          beat_count
);

  localparam int unsigned PW  = umi_pkt_w(DW, AW, CW);
  localparam int unsigned CHW = $clog2(N);

  logic [N-1:0]    full, empty, push, pop, elig;
  logic [PW-1:0]   head [N];
  arb_state_e      state_q, state_d;
  logic [CHW-1:0]  lock_q, lock_d, rr_q, rr_d, chan_q, chan_d, grant;
  logic [PW-1:0]   out_q, out_d;
  logic            valid_q, valid_d, any_elig, load;
  int unsigned     idx;

  assign in_ready = {N{nreset}} & ~full;
  assign push     = in_valid & in_ready;

  for (genvar i = 0; i < N; i++) begin : g_fifo
    umi_chan_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .nreset  (nreset),
      .push_i  (push[i]),
      .din_i   (in_data[i*PW +: PW]),
      .pop_i   (pop[i]),
      .head_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Scan downward from the farthest offset so the nearest-to-rr_q wins.
  always_comb begin
    elig     = ~empty;
    grant    = rr_q;
    any_elig = 1'b0;
    idx      = 0;
    if (state_q == ARB_LOCKED) elig = ~empty & (N'(1) << lock_q);
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % N;
      if (elig[CHW'(idx)]) begin
        grant    = CHW'(idx);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    valid_d = valid_q;
    out_d   = out_q;
    chan_d  = chan_q;
    pop     = '0;
    load    = (!valid_q || ready) && any_elig;
    if (load) begin
      pop[grant] = 1'b1;
      out_d      = head[grant];
      valid_d    = 1'b1;
      chan_d     = grant;
      lock_d     = grant;
      rr_d       = (grant == CHW'(N - 1)) ? '0 : grant + CHW'(1);
      state_d    = head[grant][EOM_BIT] ? ARB_IDLE : ARB_LOCKED;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ARB_IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      chan_q  <= chan_d;
    end
  end

  assign cmd     = out_q[CW-1:0];
  assign dstaddr = out_q[CW +: AW];
  assign srcaddr = out_q[CW+AW +: AW];
  assign data    = out_q[CW+2*AW +: DW];
  assign chan    = chan_q;
  assign valid   = valid_q;

`ifdef UMI_MULTI_QUEUE_ARB_COUNT_EN
  logic [31:0] count_q, count_d;

  assign count_d = (valid_q && ready) ? count_q + 32'd1 : count_q;

  always_ff @(posedge clk) begin
    if (!nreset) count_q <= '0;
    else         count_q <= count_d;
  end

  assign beat_count = count_q;
`else
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_umi_multi_queue_arb.sv
// Bench for umi_multi_queue_arb: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_umi_multi_queue_arb;

  localparam int unsigned N     = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 16;
  localparam int unsigned CW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned EOM   = 22;
  localparam int unsigned PW    = DW + 2 * AW + CW;

  logic            clk = 1'b0;
  logic            nreset;
  logic [N*PW-1:0] in_data;
  logic [N-1:0]    in_valid, in_ready;
  logic [DW-1:0]   data;
  logic [AW-1:0]   srcaddr, dstaddr;
  logic [CW-1:0]   cmd;
  logic [0:0]      chan;
  logic            valid, ready;
  logic [31:0]     beat_count;

  always #5 clk = ~clk;

  umi_multi_queue_arb #(.N(N), .DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH), .EOM_BIT(EOM)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .srcaddr    (srcaddr),
    .dstaddr    (dstaddr),
    .cmd        (cmd),
    .chan       (chan),
    .valid      (valid),
    .ready      (ready),
    .beat_count (beat_count)
  );

  // Reference model: one queue per channel plus the output slot.
  logic [PW-1:0] mq0[$];
  logic [PW-1:0] mq1[$];
  logic          m_valid;
  logic [PW-1:0] m_word;
  int            m_chan, m_lock, m_rr;
  bit            m_locked;
  logic [31:0]   m_count;
  bit            cnt_hold, cnt_preload;
  int            checks, fails;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int c);
    return (c == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [PW-1:0] mk(input logic [31:0] d, input logic [15:0] s,
                                       input logic [15:0] t, input bit eom);
    logic [31:0] c;
    c      = {d[7:0], 24'h000011};
    c[EOM] = eom;
    return {d, s, t, c};
  endfunction

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_valid  = 1'b0;
    m_word   = '0;
    m_chan   = 0;
    m_lock   = 0;
    m_rr     = 0;
    m_locked = 1'b0;
    m_count  = '0;
  endtask

  // Advance the model by one rising edge using the inputs held across that edge.
  task automatic model_step();
    int  sz[N];
    bit  pu[N];
    int  g;
    bit  ok;
    if (!nreset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < int'(N); c++) begin
      sz[c] = qsize(c);
      pu[c] = in_valid[c] && (sz[c] < int'(DEPTH));
    end
    if (m_valid && ready) m_count = m_count + 32'd1;
    ok = 1'b0;
    g  = 0;
    if (!m_valid || ready) begin
      if (m_locked) begin
        if (sz[m_lock] > 0) begin
          g  = m_lock;
          ok = 1'b1;
        end
      end else begin
        for (int k = 0; k < int'(N); k++) begin
          if (!ok && sz[(m_rr + k) % int'(N)] > 0) begin
            g  = (m_rr + k) % int'(N);
            ok = 1'b1;
          end
        end
      end
      if (ok) begin
        m_word   = (g == 0) ? mq0.pop_front() : mq1.pop_front();
        m_valid  = 1'b1;
        m_chan   = g;
        m_rr     = (g + 1) % int'(N);
        m_locked = !m_word[EOM];
        m_lock   = g;
      end else if (ready) begin
        m_valid = 1'b0;
      end
    end
    if (pu[0]) mq0.push_back(in_data[0 +: PW]);
    if (pu[1]) mq1.push_back(in_data[PW +: PW]);
    if (cnt_preload) m_count = 32'hFFFF_FFFE;
  endtask

  task automatic compare();
    logic [N-1:0] er;
    for (int c = 0; c < int'(N); c++) er[c] = nreset && (qsize(c) < int'(DEPTH));
    chk("in_ready", 128'(in_ready), 128'(er));
    chk("valid", 128'(valid), 128'(m_valid));
    if (m_valid) begin
      chk("data", 128'(data), 128'(m_word[CW+2*AW +: DW]));
      chk("srcaddr", 128'(srcaddr), 128'(m_word[CW+AW +: AW]));
      chk("dstaddr", 128'(dstaddr), 128'(m_word[CW +: AW]));
      chk("cmd", 128'(cmd), 128'(m_word[CW-1:0]));
      chk("chan", 128'(chan), 128'(m_chan));
    end
`ifdef UMI_MULTI_QUEUE_ARB_COUNT_EN
    if (!cnt_hold) chk("beat_count", 128'(beat_count), 128'(m_count));
`else
    chk("beat_count", 128'(beat_count), 128'd0);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ch(input int c, input logic [PW-1:0] w);
    in_data[c*PW +: PW] = w;
  endtask

  int acc, ne;
  bit exp_v[6];
  int exp_c[6];

  initial begin
    checks      = 0;
    fails       = 0;
    cnt_hold    = 1'b0;
    cnt_preload = 1'b0;
    model_reset();
    nreset   = 1'b0;
    ready    = 1'b1;
    in_valid = 2'b11;
    set_ch(0, mk(32'hA0, 16'h1, 16'h2, 1'b1));
    set_ch(1, mk(32'hB0, 16'h3, 16'h4, 1'b1));

    // Reset held with valid inputs asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_valid", 128'(valid), 128'd0);
      chk("rst_beat_count", 128'(beat_count), 128'd0);
    end
    nreset = 1'b1;
    tick();
    in_valid = 2'b00;
    chk("first_lat1_valid", 128'(valid), 128'd0);
    tick();
    chk("first_lat2_valid", 128'(valid), 128'd1);
    chk("first_lat2_chan", 128'(chan), 128'd0);
    chk("first_lat2_data", 128'(data), 128'hA0);
    tick();
    chk("second_chan", 128'(chan), 128'd1);
    tick();
    chk("idle_valid", 128'(valid), 128'd0);

    // Round-robin with single-beat messages.
    ready    = 1'b0;
    in_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, mk(32'h100 + 32'(i), 16'h10, 16'h20, 1'b1));
      set_ch(1, mk(32'h200 + 32'(i), 16'h30, 16'h40, 1'b1));
      tick();
    end
    in_valid = 2'b00;
    chk("rr_chan0", 128'(chan), 128'd0);
    chk("rr_valid0", 128'(valid), 128'd1);
    ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      tick();
      chk("rr_chan", 128'(chan), 128'(k % 2));
      chk("rr_valid", 128'(valid), 128'd1);
    end
    tick();
    chk("rr_end_valid", 128'(valid), 128'd0);

    // Message atomicity: ch0 3-beat message with a gap; ch1 always valid.
    exp_v = '{1, 1, 0, 0, 1, 1};
    exp_c = '{0, 0, 0, 0, 0, 1};
    for (int t = 1; t <= 7; t++) begin
      in_valid[0] = (t == 1 || t == 2 || t == 5);
      in_valid[1] = 1'b1;
      set_ch(0, mk(32'h300 + 32'(t), 16'h50, 16'h60, t == 5));
      set_ch(1, mk(32'h400 + 32'(t), 16'h70, 16'h80, 1'b1));
      tick();
      if (t >= 2) begin
        chk("atom_valid", 128'(valid), 128'(exp_v[t-2]));
        if (exp_v[t-2]) chk("atom_chan", 128'(chan), 128'(exp_c[t-2]));
      end
      if (t == 6) chk("atom_eom", 128'(cmd[EOM]), 128'd1);
    end
    in_valid = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    chk("atom_drained", 128'(valid), 128'd0);

    // Backpressure: ch0 streams into a stalled output.
    ready    = 1'b0;
    in_valid = 2'b01;
    acc      = 0;
    for (int i = 0; i < 10; i++) begin
      set_ch(0, mk(32'(acc), 16'h90, 16'hA0, 1'b1));
      if (in_ready[0]) acc++;
      tick();
    end
    chk("bp_accepted", 128'(acc), 128'(DEPTH + 1));
    chk("bp_in_ready", 128'(in_ready[0]), 128'd0);

    // Full FIFO: pop without same-cycle push, then ready reopens.
    ready = 1'b1;
    set_ch(0, mk(32'd99, 16'h90, 16'hA0, 1'b1));
    ne = 0;
    if (valid) begin
      chk("drain_data", 128'(data), 128'(ne));
      ne++;
    end
    tick();
    chk("full_pop_in_ready", 128'(in_ready[0]), 128'd1);
    in_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      if (valid) begin
        chk("drain_data", 128'(data), 128'(ne));
        ne++;
      end
      tick();
    end
    chk("drain_count", 128'(ne), 128'(DEPTH + 1));

`ifdef UMI_MULTI_QUEUE_ARB_COUNT_EN
    // Counter wrap from a forced preload.
    ready       = 1'b0;
    cnt_hold    = 1'b1;
    cnt_preload = 1'b1;
    force dut.count_q = 32'hFFFF_FFFE;
    tick();
    cnt_preload = 1'b0;
    release dut.count_q;
    cnt_hold = 1'b0;
    ready    = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      in_valid = (t <= 3) ? 2'b01 : 2'b00;
      set_ch(0, mk(32'h500 + 32'(t), 16'h1, 16'h1, 1'b1));
      tick();
      if (t == 3) chk("cnt_ffff", 128'(beat_count), 128'hFFFF_FFFF);
      if (t == 4) chk("cnt_wrap0", 128'(beat_count), 128'd0);
      if (t == 5) chk("cnt_one", 128'(beat_count), 128'd1);
    end
`endif

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      nreset   = !(i == 700 || i == 701);
      ready    = ($urandom_range(3) != 0);
      in_valid = N'($urandom);
      for (int c = 0; c < int'(N); c++)
        set_ch(c, mk($urandom, 16'($urandom), 16'($urandom), $urandom_range(2) != 0));
      tick();
    end
    nreset   = 1'b1;
    in_valid = 2'b00;
    ready    = 1'b1;
    for (int i = 0; i < 20; i++) tick();
`ifndef UMI_MULTI_QUEUE_ARB_COUNT_EN
    chk("cnt_tied_zero", 128'(beat_count), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/umi_multi_queue_arb.md
Name: umi_multi_queue_arb

Overview:
- Parametrised successor to the single-channel queue-to-UMI source.
- Accepts N independent packed UMI streams, each packed as {data, srcaddr, dstaddr, cmd} with valid/ready.
- Buffers each stream in a per-channel FIFO and merges them onto one registered UMI output port.
- Arbitration is round-robin and message-atomic: an arbitration lock is held until a beat with the EOM bit set.
- Sits between switchboard queue sources (or any UMI producers) and a single UMI consumer in testbenches and emulation tops.

Parameters:
- N, 2, number of input channels (>=2).
- DW, 256, UMI data width.
- AW, 64, UMI address width.
- CW, 32, UMI command width.
- DEPTH, 4, per-channel FIFO depth in beats (power of 2, >=2).
- EOM_BIT, 22, bit index of end-of-message within cmd.

Ports:
- clk  input  1  clock.
- nreset  input  1  synchronous active-low reset.
- in_data  input  N*(DW+2*AW+CW)  channel i occupies slice i; per channel packed MSB..LSB {data, srcaddr, dstaddr, cmd}.
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready.
- data  output  DW  UMI data.
- srcaddr  output  AW  UMI source address.
- dstaddr  output  AW  UMI destination address.
- cmd  output  CW  UMI command.
- chan  output  max(1,$clog2(N))  source channel of the current output beat.
- valid  output  1  output valid.
- ready  input  1  output ready.
- beat_count  output  32  accepted output beats (see Optional Feature).

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low on nreset, sampled at the rising edge of clk.
- Reset values: valid=0; data/srcaddr/dstaddr/cmd/chan=0; all FIFOs empty; in_ready=0 while nreset=0, then all 1; lock cleared; round-robin pointer=0; beat_count=0.
- Reset mid-operation: all buffered and in-flight beats are discarded. No partial message is emitted after reset.
- Input handshake: transfer on channel i when in_valid[i]&&in_ready[i] at the clock edge.
- in_ready[i] = nreset && !full[i], i.e. combinational from FIFO state only, never from in_valid.
- A full FIFO does not accept a push in the same cycle it pops (no pass-through). in_ready rises the cycle after the pop.
- Output register loads when (!valid || ready) and an eligible FIFO is non-empty. That pops the head beat, sets valid=1 and chan=granted channel.
- Output handshake: transfer when valid&&ready. If valid&&!ready, all output fields hold stable.
- If no beat is eligible while ready is high, valid drops to 0.
- Latency: a beat pushed at edge t reaches valid=1 no earlier than the cycle after edge t+1 (2 cycles). No empty-FIFO bypass.
- Throughput: with ready=1, one beat per cycle sustained.
- Arbiter states:
  - IDLE: eligible = all non-empty channels. Grant the first one scanning from rr_ptr upward, modulo N.
  - On grant of g: rr_ptr <= (g+1) mod N. If the popped cmd[EOM_BIT]==0, go to LOCKED(g).
  - LOCKED(g): only channel g is eligible. If FIFO g is empty, the output bubbles (valid=0 once drained); no other channel is granted.
  - Popping a beat from g with cmd[EOM_BIT]==1 returns to IDLE.
- Single-beat messages (EOM=1) never lock.
- Simultaneous push and pop on a non-full, non-empty FIFO: both occur and the occupancy is unchanged.
- FIFO pointers are $clog2(DEPTH)+1 bits with a wrap bit. full = MSBs differ, low bits equal.

Optional Feature:
- Macro: UMI_MULTI_QUEUE_ARB_COUNT_EN.
- Defined: beat_count increments by 1 on every output valid&&ready, wraps 2^32-1 -> 0, and resets to 0.
- Undefined: beat_count is tied to 0 and no counter flops exist.

Decomposition:
- Package umi_multi_queue_arb_pkg:
  - function umi_pkt_w(DW,AW,CW) returning DW+2*AW+CW.
  - default EOM_BIT localparam.
  - typedef enum {ARB_IDLE, ARB_LOCKED} for the arbiter state.
- One sub-module, umi_chan_fifo: DEPTH x width, synchronous nreset, push/pop/full/empty/head data.
- Instantiated N times via generate.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with in_valid=all 1 -> in_ready=0, valid=0, beat_count=0. First beat is visible 2 cycles after nreset rises.
- Round-robin: N=2, both channels preloaded with 3 single-beat messages (EOM=1), ready=1 -> chan sequence 0,1,0,1,0,1, one beat per cycle.
- Message atomicity: ch0 sends a 3-beat message (EOM only on beat 3) with a 2-cycle gap before beat 3; ch1 is continuously valid -> no ch1 beat appears until ch0 beat 3 is output; valid=0 during the gap.
- Backpressure: ready=0 for 10 cycles with ch0 streaming -> in_ready[0]=0 after DEPTH+1 beats accepted; output fields stable. Release ready -> beats emerge in order, none lost or duplicated.
- Full-FIFO pop/push: FIFO full, ready=1 and in_valid=1 -> no push on the pop cycle; in_ready=1 next cycle.
- Counter (macro defined): preload beat_count to 32'hFFFF_FFFE via force, then 3 transfers -> 32'hFFFF_FFFF, 0, 1. Without the macro, beat_count stays 0.
